// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one i2c_master among NREQ requesters, with a bus-free gap.
// Optional start-to-done timeout is compiled in when I2C_ARB_TIMEOUT_EN is defined.
module i2c_txn_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 200,
  parameter int TIMEOUT    = 8191
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [ID_W-1:0]   grant_id,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              arb_busy,
  output logic              m_start,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_data,
  input  logic              m_busy,
  input  logic              m_done,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req[i] (level) and holds it until ack[i] or err pulses; gnt[i]
  // stays high from issue to completion, and the winner's bytes are captured on the grant edge.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   gnt_nxt, ack_nxt, win_onehot, id_onehot;
  logic [ID_W-1:0]   grant_id_nxt, rr_ptr, rr_ptr_nxt, win_id, next_ptr, cand;
  logic [ID_W:0]     sum;
  logic              win_found, m_start_nxt, err_nxt, arb_busy_nxt, tmo_hit;
  logic [7:0]        m_addr_nxt, m_data_nxt, win_addr, win_data;
  logic [15:0]       gap_cnt, gap_cnt_nxt;

  assign dbg_state = state;

  // First requester found walking upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      cand = sum[ID_W-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    id_onehot  = '0;
    win_addr   = '0;
    win_data   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == win_id) begin
        win_onehot[k] = 1'b1;
        win_addr      = req_addr[8*k +: 8];
        win_data      = req_data[8*k +: 8];
      end
      if (ID_W'(k) == grant_id) id_onehot[k] = 1'b1;
    end
    next_ptr = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Cleared while idle, so it restarts from zero on the edge that issues m_start.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tmo_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE) tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_hit = (state == WAIT_BUSY || state == WAIT_DONE) && (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    grant_id_nxt = grant_id;
    ack_nxt      = '0;
    err_nxt      = 1'b0;
    m_start_nxt  = 1'b0;
    m_addr_nxt   = m_addr;
    m_data_nxt   = m_data;
    rr_ptr_nxt   = rr_ptr;
    gap_cnt_nxt  = gap_cnt;
    unique case (state)
      IDLE: begin
        if (win_found && !m_busy) begin
          gnt_nxt      = win_onehot;
          grant_id_nxt = win_id;
          m_addr_nxt   = win_addr;
          m_data_nxt   = win_data;
          m_start_nxt  = 1'b1;
          state_nxt    = WAIT_BUSY;
        end
      end
      WAIT_BUSY, WAIT_DONE: begin
        // A done arriving on the timeout edge is still a completion.
        if (m_done || tmo_hit) begin
          gnt_nxt     = '0;
          rr_ptr_nxt  = next_ptr;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
          if (m_done) ack_nxt = id_onehot;
          else        err_nxt = 1'b1;
        end else if (state == WAIT_BUSY && m_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
    arb_busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      grant_id <= '0;
      ack      <= '0;
      err      <= 1'b0;
      arb_busy <= 1'b0;
      m_start  <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      grant_id <= grant_id_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      arb_busy <= arb_busy_nxt;
      m_start  <= m_start_nxt;
      m_addr   <= m_addr_nxt;
      m_data   <= m_data_nxt;
      rr_ptr   <= rr_ptr_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural i2c_master model (GAP_CYCLES=4, TIMEOUT=50).
// The timeout scenario is built only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_txn_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int GAP  = 4;
  localparam int TMO  = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_addr = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic [ID_W-1:0]   grant_id;
  logic              err, arb_busy, m_start;
  logic [7:0]        m_addr, m_data;
  logic              m_busy, m_done;
  logic [1:0]        dbg_state;

  // master model state
  logic mdl_busy = 1'b0;
  logic mdl_done = 1'b0;
  logic ext_busy = 1'b0;
  int   done_delay = 3;
  bit   never_done = 1'b0;
  bit   pend = 1'b0;
  bit   active = 1'b0;
  int   mcnt = 0;

  assign m_busy = mdl_busy | ext_busy;
  assign m_done = mdl_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [ID_W-1:0] exp_q[$];

  i2c_txn_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .grant_id(grant_id), .ack(ack), .err(err), .arb_busy(arb_busy),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .m_busy(m_busy), .m_done(m_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Master model: busy rises one cycle after start, done pulses done_delay cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mdl_done = 1'b0;
      if (rst || err) begin
        pend     = 1'b0;
        active   = 1'b0;
        mdl_busy = 1'b0;
      end else begin
        if (active) begin
          mcnt++;
          if (mcnt == done_delay && !never_done) begin
            mdl_done = 1'b1;
            mdl_busy = 1'b0;
            active   = 1'b0;
          end
        end
        if (pend) begin
          pend     = 1'b0;
          active   = 1'b1;
          mcnt     = 0;
          mdl_busy = 1'b1;
        end
        if (m_start) pend = 1'b1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    ext_busy = 1'b0;
    never_done = 1'b0;
    done_delay = 3;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (m_start) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (ack != '0 || err) begin
        cyc = i;
        break;
      end
    end
  endtask

  int cyc;
  int starts;
  logic [ID_W-1:0] expg;

  initial begin
    // Test 1: single requester 2
    apply_reset();
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_busy", arb_busy, 0);
    check_eq("rst_start", m_start, 0);
    check_eq("rst_addr", m_addr, 0);
    check_eq("rst_state", dbg_state, 0);
    req_addr[23:16] = 8'hA0;
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    check_eq("t1_no_early_start", m_start, 0);
    @(negedge clk);
    check_eq("t1_start", m_start, 1);
    check_eq("t1_gnt", gnt, 4'b0100);
    check_eq("t1_gid", grant_id, 2);
    check_eq("t1_addr", m_addr, 8'hA0);
    check_eq("t1_data", m_data, 8'h5A);
    check_eq("t1_arb_busy", arb_busy, 1);
    @(negedge clk);
    check_eq("t1_start_pulse", m_start, 0);
    wait_ack(cyc);
    check_eq("t1_ack_lat", cyc, 4);
    check_eq("t1_ack", ack, 4'b0100);
    check_eq("t1_gnt_clr", gnt, 0);
    check_eq("t1_err", err, 0);
    req = '0;
    @(negedge clk);
    check_eq("t1_ack_pulse", ack, 0);
    check_eq("t1_gap_busy", arb_busy, 1);

    // Test 2: all requesting, round-robin with gap
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_start(cyc);
      check_eq("t2_start_seen", cyc > 0, 1);
      if (t > 0) check_eq("t2_gap_len", cyc - 1, GAP);
      expg = exp_q.pop_front();
      check_eq("t2_gid", grant_id, expg);
      check_eq("t2_gnt", gnt, 1 << expg);
      wait_ack(cyc);
      check_eq("t2_ack", ack, 1 << expg);
    end
    req = '0;

    // Test 3: req dropped mid-transaction, bytes changed after grant
    apply_reset();
    req_addr[15:8] = 8'h3C;
    req_data[15:8] = 8'hC3;
    req = 4'b0010;
    wait_start(cyc);
    check_eq("t3_gid", grant_id, 1);
    tick(3);
    req = '0;
    req_addr[15:8] = 8'hFF;
    req_data[15:8] = 8'h00;
    wait_ack(cyc);
    check_eq("t3_ack", ack, 4'b0010);
    check_eq("t3_addr_kept", m_addr, 8'h3C);
    check_eq("t3_data_kept", m_data, 8'hC3);

    // Test 4: reset in WAIT_DONE; rr_ptr must return to 0
    apply_reset();
    req = 4'b0100;
    wait_start(cyc);
    wait_ack(cyc);
    req = 4'b1000;
    done_delay = 20;
    wait_start(cyc);
    check_eq("t4_gid3", grant_id, 3);
    tick(2);
    check_eq("t4_in_wait_done", dbg_state, 2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_rst_gnt", gnt, 0);
    check_eq("t4_rst_gid", grant_id, 0);
    check_eq("t4_rst_ack", ack, 0);
    check_eq("t4_rst_err", err, 0);
    check_eq("t4_rst_busy", arb_busy, 0);
    check_eq("t4_rst_start", m_start, 0);
    check_eq("t4_rst_addr", m_addr, 0);
    check_eq("t4_rst_data", m_data, 0);
    check_eq("t4_rst_state", dbg_state, 0);
    done_delay = 3;
    rst = 1'b0;
    req = 4'b1010;
    wait_start(cyc);
    check_eq("t4_regrant_lat", cyc, 1);
    check_eq("t4_rr_from_0", grant_id, 1);
    wait_ack(cyc);
    check_eq("t4_ack", ack, 4'b0010);
    req = '0;

    // Test 6: external busy holds off the grant
    apply_reset();
    ext_busy = 1'b1;
    tick(1);
    req = 4'b0001;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_start) starts++;
    end
    check_eq("t6_no_start", starts, 0);
    check_eq("t6_idle", arb_busy, 0);
    ext_busy = 1'b0;
    wait_start(cyc);
    check_eq("t6_start_lat", cyc, 1);
    check_eq("t6_gid", grant_id, 0);
    wait_ack(cyc);
    check_eq("t6_ack", ack, 4'b0001);
    req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Test 5: master never completes
    apply_reset();
    never_done = 1'b1;
    req = 4'b0011;
    wait_start(cyc);
    check_eq("t5_gid0", grant_id, 0);
    wait_ack(cyc);
    check_eq("t5_err_lat", cyc, TMO);
    check_eq("t5_err", err, 1);
    check_eq("t5_no_ack", ack, 0);
    check_eq("t5_gnt_clr", gnt, 0);
    check_eq("t5_gid_kept", grant_id, 0);
    never_done = 1'b0;
    @(negedge clk);
    check_eq("t5_err_pulse", err, 0);
    wait_start(cyc);
    check_eq("t5_gap_len", cyc, GAP);
    check_eq("t5_next_gid", grant_id, 1);
    wait_ack(cyc);
    check_eq("t5_ack1", ack, 4'b0010);
    req = '0;
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
